// File: rtl/immediate_encode_pkg.sv
// Shared definitions for the RV32 immediate encoder: IMM_SEL codes, the
// stage-1 field bundle and the per-format immediate range check.
package immediate_encode_pkg;

  typedef enum logic [2:0] {
    IMM_U     = 3'b000,
    IMM_J     = 3'b001,
    IMM_S     = 3'b010,
    IMM_B     = 3'b011,
    IMM_I     = 3'b100,
    IMM_SHIFT = 3'b101,
    IMM_IU    = 3'b110,
    IMM_ILL   = 3'b111
  } imm_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    imm_sel_e    sel;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } enc_fields_t;

  // True when the immediate cannot be represented exactly in the chosen format.
  function automatic logic imm_range_err(input logic [31:0] imm, input imm_sel_e sel);
    logic err;
    err = 1'b1;
    case (sel)
      IMM_U:        err = (imm[11:0] != 12'h000);
      IMM_J:        err = imm[0] || (imm[31:20] != {12{imm[20]}});
      IMM_B:        err = imm[0] || (imm[31:12] != {20{imm[12]}});
      IMM_S, IMM_I: err = !((imm[31:11] == '0) || (imm[31:11] == '1));
      IMM_SHIFT:    err = (imm[31:5] != '0);
      IMM_IU:       err = (imm[31:12] != '0);
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/immediate_encode_if.sv
// Loader-side bus of the immediate encoder: input field word with valid/ready
// and the encoded, address-tagged output word with valid/ready.
interface immediate_encode_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           imm;
  logic [2:0]            imm_sel;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           instr;
  logic                  out_err;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output in_valid, imm, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, out_ready,
    input  in_ready, out_valid, instr, out_err, out_addr
  );

  modport slave (
    input  in_valid, imm, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, out_ready,
    output in_ready, out_valid, instr, out_err, out_addr
  );
endinterface

// File: rtl/immediate_encode_field_pack.sv
// Combinational packer: places immediate bits and register/opcode fields into
// an RV32 instruction word and flags immediates the format cannot hold.
module immediate_encode_field_pack
  import immediate_encode_pkg::*;
(
  input  enc_fields_t f,
  output logic [31:0] instr,
  output logic        range_err
);

  always_comb begin
    instr = NOP_INSTR;
    case (f.sel)
      IMM_U:         instr = {f.imm[31:12], f.rd, f.opcode};
      IMM_J:         instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      IMM_S:         instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      IMM_B:         instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                              f.imm[4:1], f.imm[11], f.opcode};
      IMM_I, IMM_IU: instr = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      IMM_SHIFT:     instr = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
      default:       instr = NOP_INSTR;
    endcase
  end

  assign range_err = imm_range_err(f.imm, f.sel);

endmodule

// File: rtl/immediate_encode.sv
// Two-stage valid/ready RV32 instruction encoder for the program loader:
// packs fields per IMM_SEL, tags words with a byte address, counts range errors.
module immediate_encode
  import immediate_encode_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    ERR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  immediate_encode_if.slave    bus,
  output logic [ERR_WIDTH-1:0] err_count
);

  logic                  vld_p1;
  logic                  vld_p2;
  logic                  adv_p2;
  logic                  in_ready;
  enc_fields_t           fields_in;
  enc_fields_t           fields_p1;
  logic [31:0]           pack_instr;
  logic                  pack_err;
  logic [31:0]           instr_p2;
  logic                  err_p2;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ERR_WIDTH-1:0]  err_cnt_q;

  assign fields_in = '{sel:    imm_sel_e'(bus.imm_sel),
                       imm:    bus.imm,
                       opcode: bus.opcode,
                       rd:     bus.rd,
                       rs1:    bus.rs1,
                       rs2:    bus.rs2,
                       funct3: bus.funct3,
                       funct7: bus.funct7};

  assign adv_p2   = !vld_p2 || bus.out_ready;
  assign in_ready = !vld_p1 || adv_p2;

  // Stage 1: capture raw fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (in_ready)
      vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid && in_ready)
      fields_p1 <= fields_in;
  end

  immediate_encode_field_pack u_pack (
    .f         (fields_p1),
    .instr     (pack_instr),
    .range_err (pack_err)
  );

  // Stage 2: packed word and error flag, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      err_p2   <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        instr_p2 <= pack_instr;
        err_p2   <= pack_err;
      end
    end
  end

  // Delivery-side address tag and saturating error count; clear overrides a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= BASE_ADDR;
      err_cnt_q <= '0;
    end else if (clear) begin
      addr_q    <= BASE_ADDR;
      err_cnt_q <= '0;
    end else if (vld_p2 && bus.out_ready) begin
      addr_q <= addr_q + ADDR_WIDTH'(4);
      if (err_p2 && (err_cnt_q != {ERR_WIDTH{1'b1}}))
        err_cnt_q <= err_cnt_q + ERR_WIDTH'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2;
  assign bus.instr     = instr_p2;
  assign bus.out_err   = err_p2;
  assign bus.out_addr  = addr_q;
  assign err_count     = err_cnt_q;

endmodule
